insa_trace_buffer: RTL

//  Circular capture buffer feeding the ALU's INSA read port. The commit stage pushes 32-bit

---
 rtl/insa_trace_buffer_pkg.sv | 9 +
 rtl/insa_buf_ptr_ctrl.sv | 80 ++++++++
 rtl/insa_trace_buffer.sv | 73 +++++++
 3 files changed

// File: rtl/insa_trace_buffer_pkg.sv
// Shared definitions for the INSA trace buffer and the ALU that reads it.
package insa_trace_buffer_pkg;

  localparam int unsigned INSA_BUF_DEPTH = 16;
  localparam int unsigned INSA_IDX_W     = 20;

  typedef logic [31:0] insa_trace_t;

endpackage

// File: rtl/insa_buf_ptr_ctrl.sv
// Pointer/count bookkeeping for the INSA trace buffer: write/read pointers,
// occupancy count, and the sticky overflow and crash flags.
module insa_buf_ptr_ctrl #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_valid_i,
  input  logic             rst_buf_i,
  input  logic             en_crash_i,
  output logic             wr_en_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o,
  output logic             crash_o
);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             crash_q, crash_d;
  logic             full;

  assign full = (count_q == CNT_W'(DEPTH));

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    crash_d    = crash_q;
    wr_en_o    = push_valid_i & ~rst_buf_i;

    // Clear wins over a same-cycle push; crash survives until a core reset.
    if (rst_buf_i) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (push_valid_i) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (full) begin
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        overflow_d = 1'b1;
        if (en_crash_i) begin
          crash_d = 1'b1;
        end
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      crash_q    <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      crash_q    <= crash_d;
    end
  end

  assign rd_ptr_o   = rd_ptr_q;
  assign wr_ptr_o   = wr_ptr_q;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign crash_o    = crash_q;

endmodule

// File: rtl/insa_trace_buffer.sv
// Circular trace capture buffer with combinational oldest-end and newest-end
// indexed reads for the ALU's INSA port.
module insa_trace_buffer
  import insa_trace_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = INSA_BUF_DEPTH,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = INSA_IDX_W,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_valid_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic [IDX_W-1:0]  read_index_i,
  output logic [DATA_W-1:0] read_first_o,
  output logic [DATA_W-1:0] read_last_o,
  output logic              data_in_buffer_o,
  output logic [CNT_W-1:0]  count_o,
  input  logic              rst_buf_i,
  input  logic              en_crash_i,
  output logic              overflow_o,
  output logic              crash_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CMP_W = (IDX_W > CNT_W) ? IDX_W : CNT_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_en;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  idx_lo;
  logic [PTR_W-1:0]  first_addr;
  logic [PTR_W-1:0]  last_addr;
  logic              idx_valid;

  insa_buf_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) i_ptr_ctrl (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_valid_i (push_valid_i),
    .rst_buf_i    (rst_buf_i),
    .en_crash_i   (en_crash_i),
    .wr_en_o      (wr_en),
    .rd_ptr_o     (rd_ptr),
    .wr_ptr_o     (wr_ptr),
    .count_o      (count),
    .overflow_o   (overflow_o),
    .crash_o      (crash_o)
  );

  // Storage is intentionally not reset; the count gates every read.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr] <= push_data_i;
    end
  end

  // Full-width compare so indices at or beyond DEPTH never alias onto live entries.
  assign idx_valid  = CMP_W'(read_index_i) < CMP_W'(count);
  assign idx_lo     = read_index_i[PTR_W-1:0];
  assign first_addr = rd_ptr + idx_lo;
  assign last_addr  = wr_ptr - PTR_W'(1) - idx_lo;

  assign read_first_o     = idx_valid ? mem_q[first_addr] : '0;
  assign read_last_o      = idx_valid ? mem_q[last_addr] : '0;
  assign data_in_buffer_o = (count != '0);
  assign count_o          = count;

endmodule
